// File: rtl/n64_link_pkg.sv
// n64_link_pkg: shared types and constants for the N64 link scheduler.
// Holds the FSM state enum, status codes, bus direction and length limits.
package n64_link_pkg;

    typedef enum logic [2:0] {
        IDLE, LOAD, SEND, STOP, STOPW, TURN, RECV, FIN
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_SHORT   = 2'b10;
    localparam logic [1:0] ST_LONG    = 2'b11;

    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    localparam logic [5:0] MAX_TX = 6'd35;
    localparam logic [5:0] MAX_RX = 6'd33;

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'h3f) ? v : v + 6'd1;
    endfunction

endpackage

// File: rtl/n64_sched_timer.sv
// n64_sched_timer: loadable down-counter; expire is high while count is 0.
// Ports: sample_clk, reset, load/value (reload), expire (count reached 0).
module n64_sched_timer
#(
    parameter int W = 11
) (
    input  logic         sample_clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A load of N gives N full cycles before the expire cycle.
    assign expire = (cnt == '0);

endmodule

// File: rtl/n64_link_scheduler.sv
// n64_link_scheduler: sequences one half-duplex N64 transaction (TX bytes,
// stop bit, turnaround, RX gating, completion status). Owns bus direction.
// Ports: req_* (host request), pl_* (payload source), tx_* (TX engine),
// rx_* (RX engine), rsp_* (forwarded bytes), done/status (completion).
// Optional N64_SCHED_STATS_EN adds err_count (saturating non-OK count).
module n64_link_scheduler
    import n64_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES    = 1024,
    parameter int TURNAROUND_CYCLES = 4
) (
    input  logic       sample_clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_tx_len,
    input  logic [5:0] req_rx_len,
    input  logic [7:0] pl_data,
    output logic       pl_rd,
    output logic       tx_load,
    output logic [7:0] tx_byte,
    output logic       tx_stop,
    input  logic       tx_busy,
    output logic       bus_dir,
    output logic       rx_enable,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_stop,
    output logic       rsp_valid,
    output logic [7:0] rsp_byte,
`ifdef N64_SCHED_STATS_EN
    output logic [7:0] err_count,
`endif
    output logic       done,
    output logic [1:0] status
);

    localparam int TMAX = (TIMEOUT_CYCLES > TURNAROUND_CYCLES) ?
                          TIMEOUT_CYCLES : TURNAROUND_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_TURN = TW'(TURNAROUND_CYCLES - 1);
    localparam logic [TW-1:0] T_RECV = TW'(TIMEOUT_CYCLES);

    state_t     state;
    state_t     state_n;
    logic [5:0] tx_len;
    logic [5:0] rx_len;
    logic [5:0] tx_cnt;
    logic [5:0] rx_cnt;
    logic       long_flag;
    logic [5:0] tx_len_in;
    logic [5:0] rx_len_in;
    logic       tmr_load;
    logic [TW-1:0] tmr_value;
    logic       tmr_expire;
    logic [1:0] fin_status;
    logic       take;
    logic [5:0] rx_cnt_n;
    logic       long_n;

    n64_sched_timer #(.W(TW)) u_timer (
        .sample_clk (sample_clk),
        .reset      (reset),
        .load       (tmr_load),
        .value      (tmr_value),
        .expire     (tmr_expire)
    );

    always_comb begin
        tx_len_in = req_tx_len;
        rx_len_in = req_rx_len;
        if (req_tx_len == 6'd0) tx_len_in = 6'd1;
        if (req_tx_len > MAX_TX) tx_len_in = MAX_TX;
        if (req_rx_len > MAX_RX) rx_len_in = MAX_RX;
    end

    // Byte is counted before a same-cycle stop is evaluated.
    always_comb begin
        take     = rx_valid && (rx_cnt < rx_len);
        rx_cnt_n = take ? sat_inc6(rx_cnt) : rx_cnt;
        long_n   = long_flag | (rx_valid & ~take);
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        tmr_load   = 1'b0;
        tmr_value  = T_RECV;
        fin_status = ST_OK;
        unique case (state)
            IDLE:  if (req_valid) state_n = LOAD;
            LOAD:  state_n = SEND;
            SEND:  if (!tx_busy) state_n = (tx_cnt < tx_len) ? LOAD : STOP;
            STOP:  state_n = STOPW;
            STOPW: begin
                if (!tx_busy) begin
                    state_n   = TURN;
                    tmr_load  = 1'b1;
                    tmr_value = T_TURN;
                end
            end
            TURN: begin
                if (tmr_expire) begin
                    if (rx_len == 6'd0) begin
                        state_n = FIN;
                    end else begin
                        state_n  = RECV;
                        tmr_load = 1'b1;
                    end
                end
            end
            RECV: begin
                tmr_load = rx_valid;
                if (rx_stop) begin
                    state_n = FIN;
                    if (long_n)                fin_status = ST_LONG;
                    else if (rx_cnt_n < rx_len) fin_status = ST_SHORT;
                    else                       fin_status = ST_OK;
                end else if (tmr_expire && !rx_valid) begin
                    state_n    = FIN;
                    fin_status = ST_TIMEOUT;
                end
            end
            FIN:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            tx_len    <= 6'd1;
            rx_len    <= 6'd0;
            tx_cnt    <= 6'd0;
            rx_cnt    <= 6'd0;
            long_flag <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_byte  <= 8'h00;
            status    <= ST_OK;
        end else begin
            rsp_valid <= 1'b0;
            if (state == IDLE && req_valid) begin
                tx_len    <= tx_len_in;
                rx_len    <= rx_len_in;
                tx_cnt    <= 6'd0;
                rx_cnt    <= 6'd0;
                long_flag <= 1'b0;
            end
            if (state == LOAD) tx_cnt <= sat_inc6(tx_cnt);
            if (state == RECV) begin
                rx_cnt    <= rx_cnt_n;
                long_flag <= long_n;
                if (take) begin
                    rsp_valid <= 1'b1;
                    rsp_byte  <= rx_byte;
                end
            end
            if ((state == TURN || state == RECV) && state_n == FIN) begin
                status <= fin_status;
            end
        end
    end

`ifdef N64_SCHED_STATS_EN
    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            err_count <= 8'h00;
        end else if (state == FIN && status != ST_OK && err_count != 8'hff) begin
            err_count <= err_count + 8'h01;
        end
    end
`endif

    assign req_ready = (state == IDLE) & ~reset;
    assign pl_rd     = (state == LOAD);
    assign tx_load   = (state == LOAD);
    assign tx_byte   = (state == LOAD) ? pl_data : 8'h00;
    assign tx_stop   = (state == STOP);
    assign bus_dir   = (state inside {LOAD, SEND, STOP, STOPW}) ? DIR_TX : DIR_RX;
    assign rx_enable = (state == RECV);
    assign done      = (state == FIN);

endmodule

// File: tb/tb_n64_link_scheduler.sv
// tb_n64_link_scheduler: directed transactions against the link scheduler.
// Models the TX engine busy time and a payload source; checks via chk().
module tb_n64_link_scheduler;

    logic       sample_clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_tx_len;
    logic [5:0] req_rx_len;
    logic [7:0] pl_data;
    logic       pl_rd;
    logic       tx_load;
    logic [7:0] tx_byte;
    logic       tx_stop;
    logic       tx_busy;
    logic       bus_dir;
    logic       rx_enable;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_stop;
    logic       rsp_valid;
    logic [7:0] rsp_byte;
    logic       done;
    logic [1:0] status;
`ifdef N64_SCHED_STATS_EN
    logic [7:0] err_count;
`endif

    n64_link_scheduler dut (
        .sample_clk (sample_clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tx_len (req_tx_len),
        .req_rx_len (req_rx_len),
        .pl_data    (pl_data),
        .pl_rd      (pl_rd),
        .tx_load    (tx_load),
        .tx_byte    (tx_byte),
        .tx_stop    (tx_stop),
        .tx_busy    (tx_busy),
        .bus_dir    (bus_dir),
        .rx_enable  (rx_enable),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_stop    (rx_stop),
        .rsp_valid  (rsp_valid),
        .rsp_byte   (rsp_byte),
`ifdef N64_SCHED_STATS_EN
        .err_count  (err_count),
`endif
        .done       (done),
        .status     (status)
    );

    int n_chk = 0;
    int n_pass = 0;

    int busy_d;
    int busy_left;
    int cyc;
    int n_load, n_plrd, n_stop, n_rsp, n_done, n_rise, n_fall, dir_bad;
    int acc_cyc, fall_cyc, rxen_cyc, done_cyc;
    int last_status, rxen_at_done, rdy_after;
    int pl_idx;
    logic [7:0] payload    [64];
    logic [7:0] load_bytes [64];
    int         load_cyc   [64];
    logic [7:0] rsp_bytes  [64];
    logic prev_dir, prev_rxen, prev_done;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    initial begin
        sample_clk = 1'b0;
        forever #5 sample_clk = ~sample_clk;
    end

    // TX engine: busy for busy_d cycles starting the cycle after load/stop.
    initial begin
        tx_busy   = 1'b0;
        busy_left = 0;
        forever begin
            @(posedge sample_clk);
            #1;
            if (reset) begin
                busy_left = 0;
                tx_busy   = 1'b0;
            end else begin
                if (busy_left > 0) begin
                    tx_busy = 1'b1;
                    busy_left--;
                end else begin
                    tx_busy = 1'b0;
                end
                if (tx_load || tx_stop) busy_left = busy_d;
            end
        end
    end

    // Event monitor, sampled mid-cycle.
    initial begin
        cyc = 0;
        prev_dir = 1'b0;
        prev_rxen = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge sample_clk);
            #1;
            cyc++;
            if (req_valid && req_ready) acc_cyc = cyc;
            if (tx_load) begin
                if (n_load < 64) begin
                    load_bytes[n_load] = tx_byte;
                    load_cyc[n_load]   = cyc;
                end
                if (!bus_dir) dir_bad++;
                n_load++;
            end
            if (pl_rd) begin
                n_plrd++;
                pl_idx  = (pl_idx + 1) % 64;
                pl_data = payload[pl_idx];
            end
            if (tx_stop) begin
                n_stop++;
                if (!bus_dir) dir_bad++;
            end
            if (bus_dir && !prev_dir) n_rise++;
            if (!bus_dir && prev_dir) begin
                n_fall++;
                fall_cyc = cyc;
            end
            if (rx_enable && !prev_rxen) rxen_cyc = cyc;
            if (rsp_valid) begin
                if (n_rsp < 64) rsp_bytes[n_rsp] = rsp_byte;
                n_rsp++;
            end
            if (prev_done) rdy_after = int'(req_ready);
            if (done) begin
                n_done++;
                done_cyc     = cyc;
                last_status  = int'(status);
                rxen_at_done = int'(rx_enable);
            end
            prev_dir  = bus_dir;
            prev_rxen = rx_enable;
            prev_done = done;
        end
    end

    task automatic clr();
        n_load = 0; n_plrd = 0; n_stop = 0; n_rsp = 0; n_done = 0;
        n_rise = 0; n_fall = 0; dir_bad = 0;
        acc_cyc = -1; fall_cyc = -1; rxen_cyc = -1; done_cyc = -1;
        last_status = -1; rxen_at_done = -1; rdy_after = -1;
        pl_idx  = 0;
        pl_data = payload[0];
    endtask

    task automatic start_req(input int tl, input int rl);
        @(negedge sample_clk);
        req_tx_len = 6'(tl);
        req_rx_len = 6'(rl);
        req_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) break;
            @(negedge sample_clk);
        end
        @(negedge sample_clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rxen(input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            @(negedge sample_clk);
            if (rx_enable) break;
        end
        chk(tag, int'(rx_enable), 1);
    endtask

    task automatic wait_done(input int target, input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if (n_done >= target) break;
            @(negedge sample_clk);
        end
        repeat (2) @(negedge sample_clk);
        chk(tag, n_done, target);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_valid = 1'b1;
        rx_byte  = b;
        rx_stop  = stop;
        @(negedge sample_clk);
        rx_valid = 1'b0;
        rx_stop  = 1'b0;
        @(negedge sample_clk);
    endtask

    task automatic send_stop();
        rx_stop = 1'b1;
        @(negedge sample_clk);
        rx_stop = 1'b0;
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        req_valid = 1'b0;
        req_tx_len = 6'd0;
        req_rx_len = 6'd0;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        rx_stop = 1'b0;
        busy_d = 3;
        for (int i = 0; i < 64; i++) payload[i] = 8'h00;
        clr();

        repeat (3) @(negedge sample_clk);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_dir", int'(bus_dir), 0);
        chk("rst_load", int'(tx_load), 0);
        chk("rst_txbyte", int'(tx_byte), 0);
        chk("rst_rspbyte", int'(rsp_byte), 0);
        chk("rst_status", int'(status), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rxen", int'(rx_enable), 0);
`ifdef N64_SCHED_STATS_EN
        chk("rst_errcnt", int'(err_count), 0);
`endif
        reset = 1'b0;
        @(negedge sample_clk);
        chk("ready_after_rst", int'(req_ready), 1);

        // Poll: 1 command byte, 4 response bytes
        payload[0] = 8'h01;
        clr();
        busy_d = 3;
        start_req(1, 4);
        wait_rxen(100, "poll_rxen");
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        send_stop();
        wait_done(1, 50, "poll_done");
        chk("poll_nload", n_load, 1);
        chk("poll_byte0", int'(load_bytes[0]), 8'h01);
        chk("poll_nstop", n_stop, 1);
        chk("poll_acc2load", load_cyc[0] - acc_cyc, 1);
        chk("poll_turn", rxen_cyc - fall_cyc, 4);
        chk("poll_nrsp", n_rsp, 4);
        bad = 0;
        for (int i = 0; i < 4; i++) if (rsp_bytes[i] != 8'hA0 + 8'(i)) bad++;
        chk("poll_rspbytes", bad, 0);
        chk("poll_status", last_status, 0);
        chk("poll_rdy_after", rdy_after, 1);

        // Write: 35 bytes, no response
        for (int i = 0; i < 35; i++) payload[i] = 8'(i * 7 + 3);
        clr();
        busy_d = 2;
        start_req(35, 0);
        wait_done(1, 500, "wr_done");
        chk("wr_nload", n_load, 35);
        chk("wr_nplrd", n_plrd, 35);
        bad = 0;
        for (int i = 0; i < 35; i++) if (load_bytes[i] != 8'(i * 7 + 3)) bad++;
        chk("wr_order", bad, 0);
        bad = 0;
        for (int i = 0; i < 34; i++) if (load_cyc[i + 1] - load_cyc[i] != 4) bad++;
        chk("wr_spacing", bad, 0);
        chk("wr_dirbad", dir_bad, 0);
        chk("wr_nrise", n_rise, 1);
        chk("wr_nfall", n_fall, 1);
        chk("wr_fin_lat", done_cyc - fall_cyc, 4);
        chk("wr_status", last_status, 0);

        // No response -> timeout
        payload[0] = 8'h02;
        clr();
        busy_d = 3;
        start_req(1, 1);
        wait_rxen(100, "to_rxen");
        wait_done(1, 1200, "to_done");
        chk("to_status", last_status, 1);
        chk("to_latency", done_cyc - rxen_cyc, 1025);
        chk("to_rxen_off", rxen_at_done, 0);
        chk("to_nrsp", n_rsp, 0);

        // Short response
        clr();
        start_req(1, 3);
        wait_rxen(100, "short_rxen");
        send_byte(8'hB0, 1'b0);
        send_byte(8'hB1, 1'b0);
        send_stop();
        wait_done(1, 50, "short_done");
        chk("short_status", last_status, 2);
        chk("short_nrsp", n_rsp, 2);

        // Long response
        clr();
        start_req(1, 3);
        wait_rxen(100, "long_rxen");
        for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b0);
        send_stop();
        wait_done(1, 50, "long_done");
        chk("long_status", last_status, 3);
        chk("long_nrsp", n_rsp, 3);
        chk("long_last", int'(rsp_bytes[2]), 8'hC2);

        // Final byte and stop in the same cycle
        clr();
        start_req(1, 2);
        wait_rxen(100, "same_rxen");
        send_byte(8'hD0, 1'b0);
        send_byte(8'hD1, 1'b1);
        wait_done(1, 50, "same_done");
        chk("same_status", last_status, 0);
        chk("same_nrsp", n_rsp, 2);
        chk("same_last", int'(rsp_bytes[1]), 8'hD1);

        // rx_valid on the timer expiry cycle wins
        clr();
        start_req(1, 2);
        wait_rxen(100, "exp_rxen");
        repeat (1024) @(negedge sample_clk);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hE1, 1'b1);
        wait_done(1, 50, "exp_done");
        chk("exp_status", last_status, 0);
        chk("exp_nrsp", n_rsp, 2);
        chk("exp_first", int'(rsp_bytes[0]), 8'hE0);
`ifdef N64_SCHED_STATS_EN
        chk("stats_errcnt", int'(err_count), 3);
`endif

        // Reset in SEND
        clr();
        busy_d = 5;
        start_req(5, 1);
        for (int i = 0; i < 100; i++) begin
            if (n_load >= 2) break;
            @(negedge sample_clk);
        end
        chk("rstm_loads", n_load, 2);
        @(negedge sample_clk);
        chk("rstm_pre_dir", int'(bus_dir), 1);
        #2 reset = 1'b1;
        #1;
        chk("rstm_dir", int'(bus_dir), 0);
        chk("rstm_ready", int'(req_ready), 0);
        chk("rstm_load", int'(tx_load), 0);
        chk("rstm_plrd", int'(pl_rd), 0);
        chk("rstm_rxen", int'(rx_enable), 0);
        chk("rstm_done", int'(done), 0);
        repeat (3) @(negedge sample_clk);
        reset = 1'b0;
        repeat (5) @(negedge sample_clk);
        chk("rstm_no_done", n_done, 0);
`ifdef N64_SCHED_STATS_EN
        chk("rstm_errcnt", int'(err_count), 0);
`endif

        // Normal request after reset
        payload[0] = 8'h01;
        clr();
        busy_d = 3;
        start_req(1, 2);
        wait_rxen(100, "post_rxen");
        send_byte(8'hF0, 1'b0);
        send_byte(8'hF1, 1'b0);
        send_stop();
        wait_done(1, 50, "post_done");
        chk("post_status", last_status, 0);
        chk("post_nrsp", n_rsp, 2);
        chk("post_byte", int'(load_bytes[0]), 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/n64_link_scheduler.md
# n64_link_scheduler

Transaction sequencer for the half-duplex N64 one-wire link. It accepts a request (command plus payload length and expected response length) and drives the byte-level TX engine through command and payload bytes and the stop bit. It then turns the bus around, gates the RX engine, forwards response bytes and reports a completion status. It sits between the console-side host logic and the bit-level rx/tx engines, and is the sole owner of bus direction (RX=0, TX=1).

## Interface
- TIMEOUT_CYCLES, 1024: sample_clk cycles allowed between response start/bytes before abort
- TURNAROUND_CYCLES, 4: sample_clk cycles between TX stop complete and rx_enable
- sample_clk  in  1  sole clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; all state to IDLE, outputs to reset values
- req_valid  in  1  request offered
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
- req_tx_len  in  6  bytes to send including command byte, 1..35; 0 treated as 1
- req_rx_len  in  6  expected response bytes, 0..33
- pl_data  in  8  current payload byte (first = command)
- pl_rd  out  1  pulse: pl_data consumed, source advances
- tx_load  out  1  pulse: tx_byte valid, start byte
- tx_byte  out  8  byte to transmit
- tx_stop  out  1  pulse: send console stop bit
- tx_busy  in  1  engine busy; high from cycle after tx_load/tx_stop until done
- bus_dir  out  1  0 = RX (line released), 1 = TX
- rx_enable  out  1  RX engine armed
- rx_valid  in  1  pulse: rx_byte complete
- rx_byte  in  8  received byte
- rx_stop  in  1  pulse: controller stop bit detected
- rsp_valid  out  1  pulse: rsp_byte valid
- rsp_byte  out  8  forwarded response byte
- done  out  1  pulse: transaction finished
- status  out  2  valid with done: 00 OK, 01 TIMEOUT, 10 SHORT, 11 LONG

## Operation
- States: IDLE, LOAD, SEND, STOP, STOPW, TURN, RECV, FIN.
- IDLE: bus_dir=0, req_ready=1. On accept: latch lengths (clamped), tx_cnt=0, rx_cnt=0, bus_dir=1, go to LOAD.
- LOAD (1 cycle): tx_load=1, tx_byte=pl_data, pl_rd=1, tx_cnt++, go to SEND.
- SEND: wait for tx_busy==0. If tx_cnt<tx_len, go to LOAD; else go to STOP.
- STOP (1 cycle): tx_stop=1, go to STOPW. STOPW: wait for tx_busy==0, then bus_dir=0 and go to TURN.
- TURN: count TURNAROUND_CYCLES. If rx_len==0, go to FIN with OK; else set rx_enable=1, load the timer with TIMEOUT_CYCLES, go to RECV.
- RECV: rx_valid reloads the timer. If rx_cnt<rx_len, forward the byte and increment rx_cnt; else set the LONG flag and drop the byte. On rx_stop: LONG if the flag is set, SHORT if rx_cnt<rx_len, else OK. On timer expiry: TIMEOUT. Any exit sets rx_enable=0 and goes to FIN.
- FIN (1 cycle): done=1, status valid, then IDLE.
- Simultaneous events: when rx_valid and rx_stop occur in the same cycle, count the byte first, then evaluate stop. When rx_valid coincides with timer expiry, rx_valid wins and the timer reloads.
- rx_cnt and tx_cnt are 6-bit and saturate; they never wrap.

## Timing
- Reset values: req_ready=0 during reset (1 from the first cycle after deassert). bus_dir=0. All pulses=0. tx_byte, rsp_byte, status=0.
- Accept to tx_load: 1 cycle. tx_load to next tx_load: tx_busy duration + 2.
- rsp_valid/rsp_byte: registered, 1 cycle after rx_valid.
- done: 1 cycle after the terminating event. req_ready is high in the cycle after done.
- Reset mid-transaction aborts the transaction: no done, bus_dir=0 immediately (asynchronous).
- tx_busy is ignored in the LOAD and STOP cycles.

## Configuration
- N64_SCHED_STATS_EN defined: adds output port err_count (8 bits). It increments on each non-OK done, saturates at 255, and is cleared by reset.
- Undefined: no port and no counter logic. All other behaviour is identical.

## Structure
- Package n64_link_pkg:
  - state enum
  - status codes (ST_OK, ST_TIMEOUT, ST_SHORT, ST_LONG)
  - direction constants DIR_RX=0, DIR_TX=1
  - length limits MAX_TX=35, MAX_RX=33
- Sub-module n64_sched_timer: loadable down-counter with an expire pulse, shared by TURN and RECV.

## Test plan
- Poll: tx_len=1, pl=0x01, rx_len=4, engine returns 4 bytes then stop -> one tx_load of 0x01, one tx_stop, 4 rsp_valid pulses with matching bytes, done with status=00.
- Write: tx_len=35 -> exactly 35 pl_rd/tx_load pairs in order, bus_dir=1 throughout, bus_dir=0 exactly TURNAROUND_CYCLES before rx_enable.
- No response: rx_len=1, no rx_valid -> done with status=01 TIMEOUT_CYCLES+1 cycles after rx_enable rises; rx_enable=0.
- Short/long: rx_len=3, 2 bytes then stop -> status=10. rx_len=3, 5 bytes then stop -> 3 rsp_valid pulses, status=11.
- Same-cycle rx_valid+rx_stop on the final byte -> byte forwarded, status=00. rx_valid on the expiry cycle -> no timeout.
- Reset asserted in SEND -> bus_dir=0 and outputs at reset values immediately, no done, next request runs normally. With N64_SCHED_STATS_EN, err_count=0 after reset.
